// File: rtl/ballot_session_ctrl.sv
// Election session sequencer: setup, poll open, one authorised ballot at a time,
// vote acknowledge, poll close, winner scan and results display.
module ballot_session_ctrl #(
  parameter int unsigned BALLOT_TIMEOUT = 1000,
  parameter int unsigned HOLD_CYCLES    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        open_poll,
  input  logic        authorize,
  input  logic        close_poll,
  input  logic [3:0]  cand_valid,
  input  logic [31:0] tally,
  output logic        ballot_open,
  output logic [3:0]  vote_accept,
  output logic [7:0]  led,
  output logic [1:0]  winner,
  output logic        tie,
  output logic        results_valid,
  output logic [7:0]  reject_cnt,
  output logic [7:0]  void_cnt
);

  localparam int unsigned TimerW = $clog2(BALLOT_TIMEOUT);
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BALLOT_TIMEOUT - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StSetup, StReady, StBallot, StAck, StScan, StClosed} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        max_q, max_d;
  logic [1:0]        winner_q, winner_d;
  logic              tie_q, tie_d;
  logic              valid_q, valid_d;
  logic [7:0]        reject_q, reject_d;
  logic [7:0]        void_q, void_d;
  logic [7:0]        led_q, led_d;
  logic [3:0]        accept_q, accept_d;
  logic              open_q, open_d;

  logic       cand_any, cand_onehot, reject_inc, void_inc;
  logic [1:0] cand_idx;
  logic [7:0] tally_b [4];
  logic [7:0] scan_byte;

  assign cand_any    = (cand_valid != 4'd0);
  assign cand_onehot = cand_any && ((cand_valid & (cand_valid - 4'd1)) == 4'd0);
  assign scan_byte   = tally_b[idx_q];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tally_b[i] = tally[8*i +: 8];
    end
  end

  always_comb begin
    case (cand_valid)
      4'b0010: cand_idx = 2'd1;
      4'b0100: cand_idx = 2'd2;
      4'b1000: cand_idx = 2'd3;
      default: cand_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    max_d      = max_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    valid_d    = valid_q;
    accept_d   = 4'd0;
    reject_inc = 1'b0;
    void_inc   = 1'b0;
    led_d      = led_q;

    case (state_q)
      StSetup: begin
        reject_inc = cand_any;
        if (open_poll) state_d = StReady;
      end
      StReady: begin
        reject_inc = cand_any;
        if (close_poll) begin
          state_d = StScan;
          idx_d   = 2'd0;
        end else if (authorize) begin
          state_d = StBallot;
          timer_d = '0;
        end
      end
      StBallot: begin
        // A valid vote wins over a timeout landing on the same cycle.
        if (cand_onehot) begin
          state_d  = StAck;
          hold_d   = '0;
          accept_d = cand_valid;
        end else begin
          reject_inc = cand_any;
          if (timer_q == TimerLast) begin
            void_inc = 1'b1;
            state_d  = StReady;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      end
      StAck: begin
        reject_inc = cand_any;
        if (hold_q == HoldLast) state_d = StReady;
        else hold_d = hold_q + HoldW'(1);
      end
      StScan: begin
        if (idx_q == 2'd0) begin
          max_d    = scan_byte;
          winner_d = 2'd0;
          tie_d    = 1'b0;
        end else if (scan_byte > max_q) begin
          max_d    = scan_byte;
          winner_d = idx_q;
          tie_d    = 1'b0;
        end else if (scan_byte == max_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = StClosed;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StClosed: ;
      default: state_d = StSetup;
    endcase

    reject_d = (reject_inc && reject_q != 8'hFF) ? reject_q + 8'd1 : reject_q;
    void_d   = (void_inc && void_q != 8'hFF) ? void_q + 8'd1 : void_q;
    open_d   = (state_d == StBallot);

    case (state_d)
      StReady:  led_d = 8'h01;
      StBallot: led_d = 8'h0F;
      StAck:    led_d = 8'hFF;
      StClosed: begin
        if (state_q != StClosed) led_d = 8'h00;
        else if (cand_onehot)    led_d = tally_b[cand_idx];
      end
      default:  led_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSetup;
      timer_q  <= '0;
      hold_q   <= '0;
      idx_q    <= 2'd0;
      max_q    <= 8'd0;
      winner_q <= 2'd0;
      tie_q    <= 1'b0;
      valid_q  <= 1'b0;
      reject_q <= 8'd0;
      void_q   <= 8'd0;
      led_q    <= 8'h00;
      accept_q <= 4'd0;
      open_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      void_q   <= void_d;
      led_q    <= led_d;
      accept_q <= accept_d;
      open_q   <= open_d;
    end
  end

  assign ballot_open   = open_q;
  assign vote_accept   = accept_q;
  assign led           = led_q;
  assign winner        = winner_q;
  assign tie           = tie_q;
  assign results_valid = valid_q;
  assign reject_cnt    = reject_q;
  assign void_cnt      = void_q;

endmodule
